// File: rtl/cnn_conv_ctrl.sv
// Fetch sequencer for a shared 3x3 convolution unit: walks an HxW map tap by tap, streams sums.
// Optional in-block ReLU on stored results when CNN_CTRL_RELU_EN is defined.
module cnn_conv_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DIM_WIDTH  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [DIM_WIDTH-1:0]    img_w_i,
  input  logic [DIM_WIDTH-1:0]    img_h_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic [9*DATA_WIDTH-1:0] win_o,
  input  logic [ACC_WIDTH-1:0]    conv_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [ACC_WIDTH-1:0]    res_data_o,
  output logic                    res_last_o
);

  localparam int unsigned NTAPS = 9;
  localparam int unsigned WIN_W = NTAPS * DATA_WIDTH;
  localparam int unsigned KW    = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_CONV  = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [DIM_WIDTH-1:0]  w_q, w_d, h_q, h_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DIM_WIDTH-1:0]  r_q, r_d, c_q, c_d;
  logic [KW-1:0]         k_q, k_d;
  logic [WIN_W-1:0]      win_q, win_d;
  logic [ACC_WIDTH-1:0]  res_data_q, res_data_d;
  logic                  res_last_q, res_last_d;
  logic                  res_valid_q, res_valid_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [1:0]            ky_c, kx_c;
  logic [ADDR_WIDTH-1:0] row_c, col_c, addr_c;
  logic                  col_end_c, row_end_c;
  logic [ACC_WIDTH-1:0]  conv_post_c;

  // Stored result: optional rectification of the conv unit sum.
`ifdef CNN_CTRL_RELU_EN
  assign conv_post_c = conv_i[ACC_WIDTH-1] ? '0 : conv_i;
`else
  assign conv_post_c = conv_i;
`endif

  assign col_end_c = (c_q == (w_q - DIM_WIDTH'(3)));
  assign row_end_c = (r_q == (h_q - DIM_WIDTH'(3)));

  // Next-state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    h_d        = h_q;
    base_d     = base_q;
    r_d        = r_q;
    c_d        = c_q;
    k_d        = k_q;
    win_d      = win_q;
    res_data_d = res_data_q;
    res_last_d = res_last_q;
    ky_c       = 2'd0;
    kx_c       = 2'd0;
    row_c      = '0;
    col_c      = '0;
    addr_c     = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          w_d    = img_w_i;
          h_d    = img_h_i;
          base_d = base_addr_i;
          r_d    = '0;
          c_d    = '0;
          k_d    = '0;
          if ((img_w_i < DIM_WIDTH'(3)) || (img_h_i < DIM_WIDTH'(3))) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (mem_gnt_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          win_d[k_q*DATA_WIDTH +: DATA_WIDTH] = mem_rdata_i;
          if (k_q == KW'(NTAPS - 1)) begin
            state_d = S_CONV;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_CONV: begin
        res_data_d = conv_post_c;
        res_last_d = row_end_c && col_end_c;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (res_ready_i) begin
          if (res_last_q) begin
            state_d = S_DONE;
          end else begin
            k_d = '0;
            if (col_end_c) begin
              c_d = '0;
              r_d = r_q + DIM_WIDTH'(1);
            end else begin
              c_d = c_q + DIM_WIDTH'(1);
            end
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Tap address for the next request, from the post-update counters.
    case (k_d)
      KW'(0): begin ky_c = 2'd0; kx_c = 2'd0; end
      KW'(1): begin ky_c = 2'd0; kx_c = 2'd1; end
      KW'(2): begin ky_c = 2'd0; kx_c = 2'd2; end
      KW'(3): begin ky_c = 2'd1; kx_c = 2'd0; end
      KW'(4): begin ky_c = 2'd1; kx_c = 2'd1; end
      KW'(5): begin ky_c = 2'd1; kx_c = 2'd2; end
      KW'(6): begin ky_c = 2'd2; kx_c = 2'd0; end
      KW'(7): begin ky_c = 2'd2; kx_c = 2'd1; end
      KW'(8): begin ky_c = 2'd2; kx_c = 2'd2; end
      default: begin ky_c = 2'd0; kx_c = 2'd0; end
    endcase
    row_c  = ADDR_WIDTH'(r_d) + ADDR_WIDTH'(ky_c);
    col_c  = ADDR_WIDTH'(c_d) + ADDR_WIDTH'(kx_c);
    addr_c = base_d + ADDR_WIDTH'(row_c * ADDR_WIDTH'(w_d)) + col_c;

    mem_req_d   = (state_d == S_FETCH);
    mem_addr_d  = (state_d == S_FETCH) ? addr_c : mem_addr_q;
    res_valid_d = (state_d == S_OUT);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      w_q         <= '0;
      h_q         <= '0;
      base_q      <= '0;
      r_q         <= '0;
      c_q         <= '0;
      k_q         <= '0;
      win_q       <= '0;
      res_data_q  <= '0;
      res_last_q  <= 1'b0;
      res_valid_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      h_q         <= h_d;
      base_q      <= base_d;
      r_q         <= r_d;
      c_q         <= c_d;
      k_q         <= k_d;
      win_q       <= win_d;
      res_data_q  <= res_data_d;
      res_last_q  <= res_last_d;
      res_valid_q <= res_valid_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign win_o       = win_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_last_o  = res_last_q;

endmodule

// File: tb/tb_cnn_conv_ctrl.sv
// Scoreboard bench for cnn_conv_ctrl: memory responder, behavioural conv unit, result monitor.
module tb_cnn_conv_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  img_w_i = '0;
  logic [7:0]  img_h_i = '0;
  logic [15:0] base_addr_i = '0;
  logic        busy_o, done_o, mem_req_o;
  logic [15:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [7:0]  mem_rdata_i = '0;
  logic [71:0] win_o;
  logic [31:0] conv_i;
  logic        res_valid_o;
  logic        res_ready_i = 1'b1;
  logic [31:0] res_data_o;
  logic        res_last_o;

  cnn_conv_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .img_w_i(img_w_i), .img_h_i(img_h_i), .base_addr_i(base_addr_i),
    .busy_o(busy_o), .done_o(done_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .win_o(win_o), .conv_i(conv_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_last_o(res_last_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int req_cnt = 0;
  bit rand_mode = 1'b0;

  logic [7:0]  mem [0:65535];
  int          wgt [9];
  logic [31:0] exp_data_q [$];
  bit          exp_last_q [$];

  // Behavioural conv unit.
  int acc;
  always_comb begin
    acc = 0;
    for (int k = 0; k < 9; k++) acc = acc + int'($signed(win_o[k*8 +: 8])) * wgt[k];
    conv_i = 32'(acc);
  end

  function automatic logic [31:0] post(input int v);
`ifdef CNN_CTRL_RELU_EN
    return (v < 0) ? 32'd0 : 32'(v);
`else
    return 32'(v);
`endif
  endfunction

  // Memory responder: single outstanding, configurable gnt and rvalid latency.
  bit          pend = 1'b0, req_seen = 1'b0, addr_bad = 1'b0;
  int          g_cnt = 0, rv_cnt = 0;
  logic [15:0] req_addr = '0;
  always @(negedge clk_i) begin
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    if (!rst_ni) begin
      pend = 1'b0; req_seen = 1'b0; addr_bad = 1'b0;
    end else if (pend) begin
      if (rv_cnt == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem[req_addr];
        pend = 1'b0;
      end else rv_cnt--;
    end else if (mem_req_o) begin
      req_cnt++;
      if (!req_seen) begin
        req_seen = 1'b1; addr_bad = 1'b0; req_addr = mem_addr_o;
        g_cnt = rand_mode ? int'($urandom_range(0, 3)) : 0;
      end else if (mem_addr_o !== req_addr) addr_bad = 1'b1;
      if (g_cnt == 0) begin
        mem_gnt_i = 1'b1;
        pend = 1'b1; req_seen = 1'b0;
        rv_cnt = (rand_mode ? int'($urandom_range(1, 4)) : 1) - 1;
        checks++;
        if (addr_bad) begin
          errors++;
          $display("FAIL addr_stable: mem_addr_o moved while req held, got %h want %h", mem_addr_o, req_addr);
        end
      end else g_cnt--;
    end
  end

  // Result monitor: pops the scoreboard on every handshake.
  bit          hold_valid = 1'b0, exp_done_now = 1'b0;
  logic [31:0] hold_data = '0, ed;
  bit          el;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      hold_valid = 1'b0; exp_done_now = 1'b0;
    end else begin
      if (exp_done_now) begin
        checks++;
        if (done_o !== 1'b1) begin
          errors++;
          $display("FAIL done_pulse: done_o=%b one cycle after last handshake, want 1", done_o);
        end
        exp_done_now = 1'b0;
      end
      if (done_o) done_cnt++;
      if (res_valid_o) begin
        if (hold_valid) begin
          checks++;
          if (res_data_o !== hold_data) begin
            errors++;
            $display("FAIL res_stable: res_data_o=%h during stall, want %h", res_data_o, hold_data);
          end
        end
        if (res_ready_i) begin
          hold_valid = 1'b0;
          checks++;
          if (exp_data_q.size() == 0) begin
            errors++;
            $display("FAIL res_unexpected: got data %h last %b, want no result", res_data_o, res_last_o);
          end else begin
            ed = exp_data_q.pop_front();
            el = exp_last_q.pop_front();
            if (res_data_o !== ed || res_last_o !== el) begin
              errors++;
              $display("FAIL res_data: got data %h last %b, want data %h last %b",
                       res_data_o, res_last_o, ed, el);
            end
            if (el) exp_done_now = 1'b1;
          end
        end else begin
          hold_valid = 1'b1;
          hold_data  = res_data_o;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic push_exp(input int v, input bit last);
    exp_data_q.push_back(post(v));
    exp_last_q.push_back(last);
  endtask

  task automatic load_ramp(input logic [15:0] base, input int w, input int h);
    for (int i = 0; i < w * h; i++) mem[16'(int'(base) + i)] = 8'(i);
  endtask

  task automatic pulse_start(input int w, input int h, input logic [15:0] base);
    img_w_i = 8'(w); img_h_i = 8'(h); base_addr_i = base;
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input logic [15:0] base,
                           input bit stall, input bit poke, input string name);
    int d0;
    int n;
    d0 = done_cnt;
    if (stall) res_ready_i = 1'b0;
    pulse_start(w, h, base);
    if (poke) begin
      tick(30);
      pulse_start(3, 3, 16'd0);
    end
    if (stall) begin
      n = 0;
      while (!res_valid_o && n < 2000) begin tick(1); n++; end
      tick(10);
      res_ready_i = 1'b1;
    end
    n = 0;
    while (done_cnt == d0 && n < 5000) begin tick(1); n++; end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s_timeout: done_o never seen, done count %0d want %0d", name, done_cnt, d0 + 1);
    end
    tick(3);
    checks++;
    if (exp_data_q.size() != 0 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL %s_drain: %0d results outstanding, %0d done pulses, want 0 and 1",
               name, exp_data_q.size(), done_cnt - d0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int r0;
    int n;
    for (int k = 0; k < 9; k++) wgt[k] = 1;

    // Reset state.
    tick(3);
    checks++;
    if ({busy_o, done_o, mem_req_o, mem_addr_o, res_valid_o, res_data_o, res_last_o, win_o} !== '0) begin
      errors++;
      $display("FAIL reset_state: outputs not all zero, busy %b req %b valid %b win %h",
               busy_o, mem_req_o, res_valid_o, win_o);
    end
    rst_ni = 1'b1;
    tick(2);

    // Single 3x3 window, pixels 1..9, unit weights.
    for (int i = 0; i < 9; i++) mem[16'(i)] = 8'(i + 1);
    push_exp(45, 1'b1);
    run_frame(3, 3, 16'd0, 1'b0, 1'b0, "single");

    // Reset while fetching abandons the frame.
    for (int k = 0; k < 9; k++) wgt[k] = (k == 4) ? 1 : 0;
    load_ramp(16'd100, 5, 4);
    d0 = done_cnt;
    pulse_start(5, 4, 16'd100);
    tick(10);
    n = 0;
    while (!mem_req_o && n < 100) begin tick(1); n++; end
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, mem_req_o, mem_addr_o, res_valid_o, res_data_o, res_last_o, win_o} !== '0) begin
      errors++;
      $display("FAIL reset_midframe: outputs not zero, busy %b req %b addr %h win %h",
               busy_o, mem_req_o, mem_addr_o, win_o);
    end
    tick(2);
    rst_ni = 1'b1;
    tick(5);
    checks++;
    if (busy_o !== 1'b0 || done_cnt != d0) begin
      errors++;
      $display("FAIL reset_idle: busy %b done pulses %0d, want 0 and 0", busy_o, done_cnt - d0);
    end

    // Row-major order with identity-centre weights; start_i mid-frame is ignored.
    push_exp(6, 1'b0);  push_exp(7, 1'b0);  push_exp(8, 1'b0);
    push_exp(11, 1'b0); push_exp(12, 1'b0); push_exp(13, 1'b1);
    run_frame(5, 4, 16'd100, 1'b0, 1'b1, "order");

    // Random memory latency, downstream stall, address wrap at the top of memory.
    rand_mode = 1'b1;
    load_ramp(16'hFFF8, 5, 4);
    push_exp(6, 1'b0);  push_exp(7, 1'b0);  push_exp(8, 1'b0);
    push_exp(11, 1'b0); push_exp(12, 1'b0); push_exp(13, 1'b1);
    run_frame(5, 4, 16'hFFF8, 1'b1, 1'b0, "stall");
    rand_mode = 1'b0;

    // Degenerate frame: no fetches, immediate done.
    d0 = done_cnt;
    r0 = req_cnt;
    pulse_start(2, 8, 16'd0);
    tick(4);
    checks++;
    if (done_cnt != d0 + 1 || req_cnt != r0) begin
      errors++;
      $display("FAIL degenerate: done pulses %0d req cycles %0d, want 1 and 0", done_cnt - d0, req_cnt - r0);
    end

    // Negative sum: -17 stored raw or rectified.
    for (int k = 0; k < 9; k++) wgt[k] = 1;
    for (int i = 0; i < 9; i++) mem[16'(200 + i)] = 8'h00;
    mem[16'd204] = 8'hEF;
    push_exp(-17, 1'b1);
    run_frame(3, 3, 16'd200, 1'b0, 1'b0, "relu");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
